// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the alu_ctrl sequencer: ALU opcodes, instruction
// field positions, FSM state encoding and the latched-instruction layout.
package alu_ctrl_pkg;

  localparam int DATA_W  = 8;
  localparam int INSTR_W = 20;

  localparam logic [3:0] SEL_ADD  = 4'b0000;
  localparam logic [3:0] SEL_SUB  = 4'b0001;
  localparam logic [3:0] SEL_MUL  = 4'b0010;
  localparam logic [3:0] SEL_DIV  = 4'b0011;
  localparam logic [3:0] SEL_SHL  = 4'b0100;
  localparam logic [3:0] SEL_SHR  = 4'b0101;
  localparam logic [3:0] SEL_ROL  = 4'b0110;
  localparam logic [3:0] SEL_ROR  = 4'b0111;
  localparam logic [3:0] SEL_AND  = 4'b1000;
  localparam logic [3:0] SEL_OR   = 4'b1001;
  localparam logic [3:0] SEL_XOR  = 4'b1010;
  localparam logic [3:0] SEL_NOR  = 4'b1011;
  localparam logic [3:0] SEL_NAND = 4'b1100;
  localparam logic [3:0] SEL_XNOR = 4'b1101;
  localparam logic [3:0] SEL_GT   = 4'b1110;
  localparam logic [3:0] SEL_EQ   = 4'b1111;

  localparam int SEL_LSB     = 16;
  localparam int RD_LSB      = 14;
  localparam int RA_LSB      = 12;
  localparam int RB_LSB      = 10;
  localparam int USE_IMM_BIT = 9;
  localparam int RSVD_BIT    = 8;
  localparam int IMM_LSB     = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [3:0]        sel;
    logic [1:0]        rd;
    logic [1:0]        ra;
    logic [1:0]        rb;
    logic              use_imm;
    logic [DATA_W-1:0] imm;
  } instr_t;

endpackage

// File: rtl/alu_ctrl_alu.sv
// 8-bit combinational ALU driven by alu_ctrl. CarryOut is always the carry
// of A+B, independent of the selected operation.
module alu
  import alu_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [3:0]        ALU_Sel,
  output logic [DATA_W-1:0] ALU_Out,
  output logic              CarryOut
);

  logic [DATA_W:0] sum_ext;

  assign sum_ext  = {1'b0, A} + {1'b0, B};
  assign CarryOut = sum_ext[DATA_W];

  always_comb begin
    ALU_Out = '0;
    case (ALU_Sel)
      SEL_ADD:  ALU_Out = sum_ext[DATA_W-1:0];
      SEL_SUB:  ALU_Out = A - B;
      SEL_MUL:  ALU_Out = A * B;
      SEL_DIV:  ALU_Out = A / B;
      SEL_SHL:  ALU_Out = A << 1;
      SEL_SHR:  ALU_Out = A >> 1;
      SEL_ROL:  ALU_Out = {A[DATA_W-2:0], A[DATA_W-1]};
      SEL_ROR:  ALU_Out = {A[0], A[DATA_W-1:1]};
      SEL_AND:  ALU_Out = A & B;
      SEL_OR:   ALU_Out = A | B;
      SEL_XOR:  ALU_Out = A ^ B;
      SEL_NOR:  ALU_Out = ~(A | B);
      SEL_NAND: ALU_Out = ~(A & B);
      SEL_XNOR: ALU_Out = ~(A ^ B);
      SEL_GT:   ALU_Out = (A > B)  ? DATA_W'(1) : DATA_W'(0);
      SEL_EQ:   ALU_Out = (A == B) ? DATA_W'(1) : DATA_W'(0);
      default:  ALU_Out = '0;
    endcase
  end

endmodule

// File: rtl/alu_ctrl.sv
// Instruction sequencer: IDLE/EXEC/RESP FSM, 4x8 register file and carry flag
// around one alu. ALU_CTRL_DIVZERO_TRAP_EN selects trapping divide-by-zero.
module alu_ctrl
  import alu_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               InstrValid,
  output logic               InstrReady,
  input  logic [INSTR_W-1:0] Instr,
  output logic               ResultValid,
  input  logic               ResultReady,
  output logic [DATA_W-1:0]  ResultData,
  output logic               ResultCarry,
  output logic               ResultZero,
  output logic               ResultErr
);

  // Both handshakes: a transfer happens on a rising edge where valid and
  // ready are both high; the source holds its payload stable until then.
  state_e            state_q, state_d;
  instr_t            instr_q, instr_d;
  logic [DATA_W-1:0] rf_q [4];
  logic [DATA_W-1:0] rf_d [4];
  logic              carry_q, carry_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              zero_q, zero_d;
  logic              err_q, err_d;
  logic              valid_q, valid_d;
  logic              ready_q, ready_d;

  logic [DATA_W-1:0] op_a, op_b, alu_b, alu_out;
  logic              alu_carry, div_zero;
  logic              unused_rsvd;

  assign unused_rsvd = Instr[RSVD_BIT];

  assign op_a     = rf_q[instr_q.ra];
  assign op_b     = instr_q.use_imm ? instr_q.imm : rf_q[instr_q.rb];
  assign div_zero = (instr_q.sel == SEL_DIV) && (op_b == '0);
  // A zero divisor never reaches the quotient path; the result is overridden.
  assign alu_b    = div_zero ? DATA_W'(1) : op_b;

  alu u_alu (
    .A        (op_a),
    .B        (alu_b),
    .ALU_Sel  (instr_q.sel),
    .ALU_Out  (alu_out),
    .CarryOut (alu_carry)
  );

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    rf_d    = rf_q;
    carry_d = carry_q;
    data_d  = data_q;
    zero_d  = zero_q;
    err_d   = err_q;
    valid_d = valid_q;
    ready_d = ready_q;
    case (state_q)
      ST_IDLE: begin
        if (InstrValid && ready_q) begin
          instr_d.sel     = Instr[SEL_LSB +: 4];
          instr_d.rd      = Instr[RD_LSB +: 2];
          instr_d.ra      = Instr[RA_LSB +: 2];
          instr_d.rb      = Instr[RB_LSB +: 2];
          instr_d.use_imm = Instr[USE_IMM_BIT];
          instr_d.imm     = Instr[IMM_LSB +: DATA_W];
          state_d         = ST_EXEC;
          ready_d         = 1'b0;
        end
      end
      ST_EXEC: begin
        state_d = ST_RESP;
        valid_d = 1'b1;
        if (div_zero) begin
`ifdef ALU_CTRL_DIVZERO_TRAP_EN
          data_d = '0;
          zero_d = 1'b0;
          err_d  = 1'b1;
`else
          data_d           = '1;
          rf_d[instr_q.rd] = '1;
          zero_d           = 1'b0;
          err_d            = 1'b0;
`endif
        end else begin
          data_d           = alu_out;
          rf_d[instr_q.rd] = alu_out;
          zero_d           = (alu_out == '0);
          err_d            = 1'b0;
          if (instr_q.sel == SEL_ADD) carry_d = alu_carry;
        end
      end
      ST_RESP: begin
        if (ResultReady) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
      rf_q    <= '{default: '0};
      carry_q <= 1'b0;
      data_q  <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      rf_q    <= rf_d;
      carry_q <= carry_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign InstrReady  = ready_q;
  assign ResultValid = valid_q;
  assign ResultData  = data_q;
  assign ResultCarry = carry_q;
  assign ResultZero  = zero_q;
  assign ResultErr   = err_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl: reference model feeds an expected queue,
// responses are popped and compared as the controller hands them back.
module tb_alu_ctrl;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_DIV = 4'h3;
  localparam logic [3:0] OP_XOR = 4'hA;

  logic        clk = 1'b0;
  logic        rst;
  logic        InstrValid, InstrReady;
  logic [19:0] Instr;
  logic        ResultValid, ResultReady;
  logic [7:0]  ResultData;
  logic        ResultCarry, ResultZero, ResultErr;

  int tests_run = 0;
  int fails = 0;

  logic [10:0] exp_q[$];
  logic [7:0]  m_rf [4];
  logic        m_carry;

  always #5 clk = ~clk;

  alu_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .InstrValid  (InstrValid),
    .InstrReady  (InstrReady),
    .Instr       (Instr),
    .ResultValid (ResultValid),
    .ResultReady (ResultReady),
    .ResultData  (ResultData),
    .ResultCarry (ResultCarry),
    .ResultZero  (ResultZero),
    .ResultErr   (ResultErr)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish before 500000");
    $fatal(1, "watchdog");
  end

  function automatic logic [19:0] mk(input logic [3:0] sel, input logic [1:0] rd,
                                     input logic [1:0] ra, input logic [1:0] rb,
                                     input logic use_imm, input logic [7:0] imm);
    return {sel, rd, ra, rb, use_imm, 1'b0, imm};
  endfunction

  function automatic logic [7:0] ref_alu(input logic [3:0] sel, input logic [7:0] a,
                                         input logic [7:0] b);
    case (sel)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a * b;
      4'h3: return a / b;
      4'h4: return {a[6:0], 1'b0};
      4'h5: return {1'b0, a[7:1]};
      4'h6: return {a[6:0], a[7]};
      4'h7: return {a[0], a[7:1]};
      4'h8: return a & b;
      4'h9: return a | b;
      4'hA: return a ^ b;
      4'hB: return ~(a | b);
      4'hC: return ~(a & b);
      4'hD: return ~(a ^ b);
      4'hE: return (a > b) ? 8'd1 : 8'd0;
      default: return (a == b) ? 8'd1 : 8'd0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
    m_carry = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_issue(input logic [19:0] ins);
    logic [3:0] sel;
    logic [7:0] a, b, r;
    logic [8:0] s;
    logic       z, e;
    sel = ins[19:16];
    a   = m_rf[ins[13:12]];
    b   = ins[9] ? ins[7:0] : m_rf[ins[11:10]];
    e   = 1'b0;
    if (sel == OP_DIV && b == 8'h00) begin
`ifdef ALU_CTRL_DIVZERO_TRAP_EN
      r = 8'h00; z = 1'b0; e = 1'b1;
`else
      r = 8'hFF; z = 1'b0; m_rf[ins[15:14]] = r;
`endif
    end else begin
      r = ref_alu(sel, a, b);
      z = (r == 8'h00);
      m_rf[ins[15:14]] = r;
      if (sel == OP_ADD) begin
        s = {1'b0, a} + {1'b0, b};
        m_carry = s[8];
      end
    end
    exp_q.push_back({r, m_carry, z, e});
  endtask

  task automatic do_reset();
    rst = 1'b1; InstrValid = 1'b0; ResultReady = 1'b0; Instr = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic send(input logic [19:0] ins);
    int n;
    n = 0;
    Instr = ins;
    InstrValid = 1'b1;
    while (InstrReady !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    tests_run++;
    if (InstrReady !== 1'b1) begin
      fails++;
      $display("FAIL send_accept: InstrReady=%b required 1 within 50 cycles", InstrReady);
    end
    model_issue(ins);
    @(posedge clk); #1;
    InstrValid = 1'b0;
  endtask

  task automatic recv(input int stall);
    int n;
    logic [10:0] held, exp;
    n = 0;
    while (ResultValid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    tests_run++;
    if (ResultValid !== 1'b1) begin
      fails++;
      $display("FAIL recv_valid: ResultValid=%b required 1 within 50 cycles", ResultValid);
      return;
    end
    held = {ResultData, ResultCarry, ResultZero, ResultErr};
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      tests_run++;
      if ({ResultValid, InstrReady, ResultData, ResultCarry, ResultZero, ResultErr} !== {1'b1, 1'b0, held}) begin
        fails++;
        $display("FAIL hold_stable: got v=%b r=%b out=%h required v=1 r=0 out=%h",
                 ResultValid, InstrReady, {ResultData, ResultCarry, ResultZero, ResultErr}, held);
      end
    end
    ResultReady = 1'b1;
    tests_run++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL sb_empty: response %h arrived with no expectation queued", held);
    end else begin
      exp = exp_q.pop_front();
      if ({ResultData, ResultCarry, ResultZero, ResultErr} !== exp) begin
        fails++;
        $display("FAIL result: got data=%h c=%b z=%b e=%b required data=%h c=%b z=%b e=%b",
                 ResultData, ResultCarry, ResultZero, ResultErr, exp[10:3], exp[2], exp[1], exp[0]);
      end
    end
    @(posedge clk); #1;
    ResultReady = 1'b0;
    tests_run++;
    if (ResultValid !== 1'b0 || InstrReady !== 1'b1) begin
      fails++;
      $display("FAIL release: got v=%b r=%b required v=0 r=1", ResultValid, InstrReady);
    end
  endtask

  task automatic read_all();
    for (int i = 0; i < 4; i++) begin
      send(mk(OP_ADD, 2'(i), 2'(i), 2'd0, 1'b1, 8'h00));
      recv(0);
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if ({InstrReady, ResultValid, ResultData, ResultCarry, ResultZero, ResultErr} !== {1'b1, 1'b0, 8'h00, 3'b000}) begin
      fails++;
      $display("FAIL reset_outputs: got rdy=%b v=%b d=%h c=%b z=%b e=%b required 1 0 00 0 0 0",
               InstrReady, ResultValid, ResultData, ResultCarry, ResultZero, ResultErr);
    end
    ResultReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (InstrReady !== 1'b1 || ResultValid !== 1'b0) begin
      fails++;
      $display("FAIL idle_ready_noeffect: got rdy=%b v=%b required 1 0", InstrReady, ResultValid);
    end
    ResultReady = 1'b0;
    read_all();
  endtask

  task automatic test_add_carry();
    do_reset();
    send(mk(OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'hFF)); recv(0);
    send(mk(OP_ADD, 2'd2, 2'd1, 2'd0, 1'b1, 8'h01)); recv(0);
    tests_run++;
    if ({ResultData, ResultCarry, ResultZero} !== {8'h00, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL add_wrap: got d=%h c=%b z=%b required 00 1 1", ResultData, ResultCarry, ResultZero);
    end
    send(mk(OP_XOR, 2'd3, 2'd1, 2'd1, 1'b0, 8'h00)); recv(1);
    tests_run++;
    if ({ResultData, ResultCarry, ResultZero} !== {8'h00, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL xor_keeps_carry: got d=%h c=%b z=%b required 00 1 1", ResultData, ResultCarry, ResultZero);
    end
  endtask

  task automatic test_back_to_back();
    int acc[2];
    int vld[2];
    int na, nv;
    logic [19:0] prog[2];
    logic [10:0] exp;
    prog[0] = mk(OP_ADD, 2'd1, 2'd1, 2'd0, 1'b1, 8'h03);
    prog[1] = mk(OP_SUB, 2'd2, 2'd1, 2'd0, 1'b1, 8'h01);
    acc = '{-100, -100}; vld = '{-200, -200};
    na = 0; nv = 0;
    ResultReady = 1'b1;
    Instr = prog[0];
    InstrValid = 1'b1;
    for (int k = 0; k < 20 && nv < 2; k++) begin
      if (ResultValid === 1'b1) begin
        vld[nv] = k; nv++;
        tests_run++;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 11'h7FF;
        if ({ResultData, ResultCarry, ResultZero, ResultErr} !== exp) begin
          fails++;
          $display("FAIL b2b_result: got %h required %h", {ResultData, ResultCarry, ResultZero, ResultErr}, exp);
        end
      end
      if (InstrValid && InstrReady === 1'b1 && na < 2) begin
        model_issue(Instr);
        acc[na] = k; na++;
      end
      @(posedge clk); #1;
      if (na == 1) Instr = prog[1];
      else if (na == 2) InstrValid = 1'b0;
    end
    InstrValid = 1'b0;
    ResultReady = 1'b0;
    tests_run++;
    if (acc[1] - acc[0] !== 3) begin
      fails++;
      $display("FAIL b2b_issue_interval: got %0d required 3", acc[1] - acc[0]);
    end
    tests_run++;
    if (vld[0] - acc[0] !== 2 || vld[1] - acc[1] !== 2) begin
      fails++;
      $display("FAIL b2b_latency: got %0d,%0d required 2,2", vld[0] - acc[0], vld[1] - acc[1]);
    end
  endtask

  task automatic test_backpressure();
    int n;
    logic [10:0] held;
    logic [19:0] nxt;
    send(mk(OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'h5A));
    n = 0;
    while (ResultValid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    held = {ResultData, ResultCarry, ResultZero, ResultErr};
    nxt = mk(OP_ADD, 2'd2, 2'd1, 2'd0, 1'b1, 8'h01);
    Instr = nxt;
    InstrValid = 1'b1;
    for (int s = 0; s < 5; s++) begin
      @(posedge clk); #1;
      tests_run++;
      if ({ResultValid, InstrReady, ResultData, ResultCarry, ResultZero, ResultErr} !== {1'b1, 1'b0, held}) begin
        fails++;
        $display("FAIL bp_stall: got v=%b r=%b out=%h required v=1 r=0 out=%h",
                 ResultValid, InstrReady, {ResultData, ResultCarry, ResultZero, ResultErr}, held);
      end
    end
    recv(0);
    send(nxt);
    recv(0);
  endtask

  task automatic test_divzero();
    do_reset();
    send(mk(OP_ADD, 2'd0, 2'd0, 2'd0, 1'b1, 8'h07)); recv(0);
    send(mk(OP_ADD, 2'd1, 2'd1, 2'd0, 1'b1, 8'h33)); recv(0);
    send(mk(OP_ADD, 2'd2, 2'd0, 2'd0, 1'b1, 8'hFF)); recv(0);
    send(mk(OP_DIV, 2'd1, 2'd0, 2'd0, 1'b1, 8'h00)); recv(1);
    tests_run++;
`ifdef ALU_CTRL_DIVZERO_TRAP_EN
    if ({ResultData, ResultCarry, ResultZero, ResultErr} !== {8'h00, 1'b1, 1'b0, 1'b1}) begin
`else
    if ({ResultData, ResultCarry, ResultZero, ResultErr} !== {8'hFF, 1'b1, 1'b0, 1'b0}) begin
`endif
      fails++;
      $display("FAIL div_zero_resp: got d=%h c=%b z=%b e=%b", ResultData, ResultCarry, ResultZero, ResultErr);
    end
    send(mk(OP_ADD, 2'd2, 2'd1, 2'd0, 1'b1, 8'h00)); recv(0);
    tests_run++;
`ifdef ALU_CTRL_DIVZERO_TRAP_EN
    if (ResultData !== 8'h33) begin
`else
    if (ResultData !== 8'hFF) begin
`endif
      fails++;
      $display("FAIL div_zero_rd: got R1=%h after divide by zero", ResultData);
    end
    send(mk(OP_DIV, 2'd3, 2'd0, 2'd0, 1'b1, 8'h02)); recv(0);
    tests_run++;
    if (ResultData !== 8'h03 || ResultErr !== 1'b0) begin
      fails++;
      $display("FAIL div_normal: got d=%h e=%b required 03 0", ResultData, ResultErr);
    end
  endtask

  task automatic test_reset_midflight();
    int n;
    send(mk(OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'h40)); recv(0);
    send(mk(OP_ADD, 2'd1, 2'd1, 2'd0, 1'b1, 8'h11));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    tests_run++;
    if (ResultValid !== 1'b0 || InstrReady !== 1'b1) begin
      fails++;
      $display("FAIL rst_exec: got v=%b r=%b required 0 1", ResultValid, InstrReady);
    end
    read_all();
    send(mk(OP_ADD, 2'd2, 2'd0, 2'd0, 1'b1, 8'h22));
    n = 0;
    while (ResultValid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    tests_run++;
    if (ResultValid !== 1'b0 || InstrReady !== 1'b1 || ResultData !== 8'h00) begin
      fails++;
      $display("FAIL rst_resp: got v=%b r=%b d=%h required 0 1 00", ResultValid, InstrReady, ResultData);
    end
    read_all();
  endtask

  task automatic test_random();
    logic [19:0] ins;
    for (int i = 0; i < 24; i++) begin
      ins = mk(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
               2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      ins[8] = 1'($urandom_range(0, 1));
      send(ins);
      recv($urandom_range(0, 2));
    end
  endtask

  initial begin
    rst = 1'b1; InstrValid = 1'b0; ResultReady = 1'b0; Instr = '0;
    model_reset();
    test_reset();
    test_add_carry();
    test_back_to_back();
    test_backpressure();
    test_divzero();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/alu_ctrl.md
# alu_ctrl

- Sequencing controller on the driving side of the 8-bit `alu`: it generates `ALU_Sel` and the A/B operands, and consumes `ALU_Out` and `CarryOut`.
- Accepts 20-bit instructions over a valid/ready handshake and reads operands from a 4×8 register file.
- Executes one operation through the `alu`, writes the result back and returns it with flags over a second valid/ready handshake.
- Sits between the instruction source and the datapath; it is the first stateful block in the CPU.

## Interface
Parameters: none. Widths are fixed at 8-bit data and 20-bit instruction.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge
- `rst`  in  1  reset, synchronous, active-high
- `InstrValid`  in  1  instruction offered
- `InstrReady`  out  1  controller can accept an instruction
- `Instr`  in  20  fields:
  - [19:16] `Sel`, driven to `ALU_Sel`
  - [15:14] `Rd`
  - [13:12] `Ra`
  - [11:10] `Rb`
  - [9] `UseImm`
  - [8] reserved, ignored
  - [7:0] `Imm`
- `ResultValid`  out  1  response available
- `ResultReady`  in  1  consumer takes the response
- `ResultData`  out  8  value written to `Rd`
- `ResultCarry`  out  1  carry flag after this instruction
- `ResultZero`  out  1  `ResultData == 0`
- `ResultErr`  out  1  instruction faulted (divide by zero, trap build only)

## Operation
- Register file R0..R3, 8 bits each, all cleared by reset.
- Operand A = `R[Ra]`.
- Operand B = `Imm` if `UseImm`, else `R[Rb]`.
- State machine:
  - IDLE: `InstrReady`=1. On `InstrValid && InstrReady`, latch `Instr` and go to EXEC.
  - EXEC (one cycle): drive `ALU_Sel`, A and B from the latched fields. At cycle end:
    - write `ALU_Out` to `R[Rd]`;
    - load the response registers;
    - update the carry flag;
    - go to RESP.
  - RESP: `ResultValid`=1, all response outputs held stable. On `ResultReady`, go to IDLE.
- Carry flag register:
  - updated only for `Sel`=0000 (add), loaded from `CarryOut`;
  - every other op leaves it unchanged;
  - `ResultCarry` shows the flag value after the update.
- `Rd` may equal `Ra` or `Rb`. Operands are read in EXEC before the write, so the old value is used.
- Divide (`Sel`=0011) with B=0: handling is set by the configuration macro (see Configuration).
- Arithmetic is modulo 256, exactly as the `alu` produces it. The controller applies no extra saturation or sign logic.

## Timing
- Reset values:
  - `InstrReady`=1, `ResultValid`=0;
  - `ResultData`=8'h00, `ResultCarry`=0, `ResultZero`=0, `ResultErr`=0;
  - state IDLE, R0..R3=0, carry flag=0.
- Accept edge E0 → EXEC during the next cycle → writeback and response registered at E1.
- `ResultValid` rises the cycle after E1, so latency from acceptance to valid is 2 cycles.
- Minimum issue interval is 3 cycles: IDLE, EXEC, RESP with `ResultReady` held high.
- `InstrReady` is 0 in EXEC and RESP. An instruction offered then is not accepted and must be held by the source.
- A `ResultReady` stall does not delay the register-file write, which always happens at E1.
- `ResultReady` asserted while `ResultValid`=0 has no effect.
- `rst` asserted in any state:
  - returns to IDLE on that edge and drops `ResultValid`;
  - the in-flight instruction is discarded with no writeback;
  - the register file and flag are cleared.
- `rst` takes priority over a simultaneous handshake.

## Configuration
- `ALU_CTRL_DIVZERO_TRAP_EN` defined:
  - divide with B=0 suppresses the register write;
  - `ResultData`=8'h00, `ResultErr`=1, `ResultZero`=0;
  - carry flag unchanged.
- Not defined:
  - the operation is still not sent to the `alu` quotient path;
  - `ResultData`=8'hFF and it is written to `Rd`;
  - `ResultErr` is tied to 0.

## Structure
- Shared package `alu_ctrl_pkg` holds:
  - the 16 `ALU_Sel` opcode constants (ADD=0000 … EQ=1111);
  - instruction field bit positions;
  - the state enum IDLE/EXEC/RESP.
- The existing `alu` is instantiated once as the only sub-module. The register file and FSM stay inline.

## Test plan
- After reset: `InstrReady`=1, `ResultValid`=0, all response outputs 0; reading R0..R3 through ADD with `Imm`=0 returns 0.
- ADD R1 = R0 + imm 8'hFF, then ADD R2 = R1 + imm 8'h01 → `ResultData`=8'h00, `ResultCarry`=1, `ResultZero`=1. Then XOR R3 = R1 ^ R1 → 8'h00, `ResultCarry` still 1.
- Back-to-back: `InstrValid` held high with two instructions and `ResultReady`=1 → second accepted exactly 3 cycles after the first; `ResultValid` at +2 cycles each.
- Backpressure: `ResultReady`=0 for 5 cycles → outputs stable, `InstrReady`=0, `Rd` already updated. A following instruction reads the new `Rd`.
- R0=8'h07, DIV R1 = R0 / imm 0:
  - trap build → `ResultErr`=1, R1 unchanged;
  - non-trap build → R1=8'hFF, `ResultErr`=0.
  - Also DIV 8'h07 / imm 2 → 8'h03 in both builds.
- `rst` pulsed during EXEC, then during RESP → next cycle in IDLE, `ResultValid`=0, no writeback, registers read back 0.
